// File: rtl/mem_responder_if.sv
// Initiator/responder memory bus for mem_responder: request fields from the
// initiator, completion, error pulse and statistics back from the responder.
interface mem_responder_if;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        req_err;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  modport master (
    output mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    input  mem_rdata, mem_resp, req_err, rd_count, wr_count
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_byte_enable, mem_wdata,
    output mem_rdata, mem_resp, req_err, rd_count, wr_count
  );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency word-array memory responder with byte-lane writes.
// Define MEM_RESPONDER_STATS_EN to build the completed read/write counters.
module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 3
) (
  input logic           clk,
  input logic           rst,
  mem_responder_if.slave bus
);

  localparam int unsigned IDX_W     = DEPTH_LOG2;
  localparam int unsigned WORDS     = 1 << DEPTH_LOG2;
  localparam logic [3:0]  WAIT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e             state_q, state_d;
  logic [3:0]         wait_q, wait_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               is_wr_q, is_wr_d;
  logic               mem_resp_q, mem_resp_d;
  logic               req_err_q, req_err_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               accept;
  logic [31:0]        mem_q [WORDS];

  // Address bits outside the word index are intentionally ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_address[31:IDX_W+2], bus.mem_address[1:0]};

  assign accept = (state_q == IDLE) && (bus.mem_read || bus.mem_write);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY > 1) begin
            state_d = BUSY;
            wait_d  = WAIT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      BUSY: begin
        if (wait_q == 4'd0) state_d = RESP;
        else                wait_d  = wait_q - 4'd1;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request capture and registered outputs; read data is sampled on entry to RESP.
  always_comb begin
    idx_d      = idx_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    is_wr_d    = is_wr_q;
    rdata_d    = rdata_q;
    req_err_d  = 1'b0;
    mem_resp_d = (state_d == RESP);
    if (accept) begin
      idx_d     = bus.mem_address[IDX_W+1:2];
      be_d      = bus.mem_byte_enable;
      wdata_d   = bus.mem_wdata;
      is_wr_d   = bus.mem_write;
      req_err_d = bus.mem_read && bus.mem_write;
    end
    if ((state_d == RESP) && !is_wr_d) rdata_d = mem_q[idx_d];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      is_wr_q    <= 1'b0;
      mem_resp_q <= 1'b0;
      req_err_q  <= 1'b0;
      rdata_q    <= 32'd0;
    end else begin
      idx_q      <= idx_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      is_wr_q    <= is_wr_d;
      mem_resp_q <= mem_resp_d;
      req_err_q  <= req_err_d;
      rdata_q    <= rdata_d;
    end
  end

  // Array is never reset; a write lands on the edge that ends RESP.
  always_ff @(posedge clk) begin
    if ((state_q == RESP) && is_wr_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem_q[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign bus.mem_rdata = rdata_q;
  assign bus.mem_resp  = mem_resp_q;
  assign bus.req_err   = req_err_q;

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] rd_count_q, rd_count_d;
  logic [15:0] wr_count_q, wr_count_d;

  always_comb begin
    rd_count_d = rd_count_q;
    wr_count_d = wr_count_q;
    if (state_q == RESP) begin
      if (is_wr_q) wr_count_d = wr_count_q + 16'd1;
      else         rd_count_d = rd_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      rd_count_q <= rd_count_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign bus.rd_count = rd_count_q;
  assign bus.wr_count = wr_count_q;
`else
  assign bus.rd_count = 16'd0;
  assign bus.wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a byte-addressed model.
module tb_mem_responder;

`ifdef MEM_RESPONDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mem_responder_if bus3 ();
  mem_responder_if bus1 ();

  mem_responder #(.DEPTH_LOG2(10), .LATENCY(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  mem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Reference: 4 KiB byte store (1024 words, byte address wraps at 4096).
  logic [7:0]  mbytes [4096];
  int          m_rd, m_wr;
  logic [31:0] m_last;

  function automatic logic [31:0] m_word(input logic [31:0] a);
    int base;
    base = int'(a & 32'h0000_0FFC);
    return {mbytes[base+3], mbytes[base+2], mbytes[base+1], mbytes[base]};
  endfunction

  // Applies one completed transaction; returns the mem_rdata seen at completion.
  function automatic logic [31:0] m_do(input bit wr, input logic [31:0] a,
                                       input logic [3:0] be, input logic [31:0] wd);
    int base;
    base = int'(a & 32'h0000_0FFC);
    if (wr) begin
      for (int i = 0; i < 4; i++) if (be[i]) mbytes[base+i] = wd[8*i +: 8];
      m_wr++;
    end else begin
      m_last = m_word(a);
      m_rd++;
    end
    return m_last;
  endfunction

  function automatic logic [15:0] exp_cnt(input int n);
    return STATS ? 16'(n) : 16'h0;
  endfunction

  // Drives one request on the LATENCY=3 instance and observes a bounded window.
  task automatic txn3(input bit rd, input bit wr, input logic [31:0] a, input logic [3:0] be,
                      input logic [31:0] wd, output logic [31:0] rdata, output int lat,
                      output int nresp, output int nerr);
    @(negedge clk);
    bus3.mem_read = rd; bus3.mem_write = wr; bus3.mem_address = a;
    bus3.mem_byte_enable = be; bus3.mem_wdata = wd;
    lat = -1; nresp = 0; nerr = 0; rdata = 32'h0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (bus3.req_err) nerr++;
      if (bus3.mem_resp) begin
        nresp++;
        if (lat < 0) begin lat = c; rdata = bus3.mem_rdata; end
        bus3.mem_read = 1'b0; bus3.mem_write = 1'b0;
      end
    end
    bus3.mem_read = 1'b0; bus3.mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus3.mem_read = 0; bus3.mem_write = 0; bus3.mem_address = 0; bus3.mem_byte_enable = 0; bus3.mem_wdata = 0;
    bus1.mem_read = 0; bus1.mem_write = 0; bus1.mem_address = 0; bus1.mem_byte_enable = 0; bus1.mem_wdata = 0;
    m_rd = 0; m_wr = 0; m_last = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (bus3.mem_resp !== 1'b0) begin errors++; $display("FAIL rst_resp got %b exp 0", bus3.mem_resp); end
    checks++; if (bus3.req_err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", bus3.req_err); end
    checks++; if (bus3.mem_rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus3.mem_rdata); end
    checks++; if (bus3.rd_count !== 16'h0) begin errors++; $display("FAIL rst_rdcnt got %h exp 0", bus3.rd_count); end
    checks++; if (bus3.wr_count !== 16'h0) begin errors++; $display("FAIL rst_wrcnt got %h exp 0", bus3.wr_count); end
    checks++; if (bus1.mem_resp !== 1'b0 || bus1.mem_rdata !== 32'h0) begin
      errors++; $display("FAIL rst_dut1 got resp %b rdata %h exp 0/0", bus1.mem_resp, bus1.mem_rdata); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus3.mem_resp !== 1'b0) begin errors++; $display("FAIL idle_resp got %b exp 0", bus3.mem_resp); end
  endtask

  task automatic test_single_word();
    logic [31:0] rdata, exp; int lat, nr, ne;
    txn3(0, 1, 32'h100, 4'hF, 32'hDEADBEEF, rdata, lat, nr, ne);
    exp = m_do(1, 32'h100, 4'hF, 32'hDEADBEEF);
    checks++; if (lat !== 3) begin errors++; $display("FAIL sw_latency got %0d exp 3", lat); end
    checks++; if (nr !== 1 || ne !== 0) begin errors++; $display("FAIL sw_pulses got resp %0d err %0d exp 1/0", nr, ne); end
    checks++; if (rdata !== exp) begin errors++; $display("FAIL sw_rdata_hold got %h exp %h", rdata, exp); end
    txn3(1, 0, 32'h100, 4'h0, 32'h0, rdata, lat, nr, ne);
    exp = m_do(0, 32'h100, 4'h0, 32'h0);
    checks++; if (rdata !== exp) begin errors++; $display("FAIL sw_read got %h exp %h", rdata, exp); end
    checks++; if (lat !== 3 || nr !== 1) begin errors++; $display("FAIL sw_read_lat got %0d/%0d exp 3/1", lat, nr); end
    checks++; if (bus3.rd_count !== exp_cnt(m_rd) || bus3.wr_count !== exp_cnt(m_wr)) begin
      errors++; $display("FAIL sw_counts got %0d/%0d exp %0d/%0d", bus3.rd_count, bus3.wr_count, exp_cnt(m_rd), exp_cnt(m_wr)); end
  endtask

  task automatic test_sub_byte();
    logic [31:0] rdata, exp; int lat, nr, ne;
    // The initiator places the byte in its own lane (lane 2 here).
    txn3(0, 1, 32'h102, 4'b0100, 32'h00AA0000, rdata, lat, nr, ne);
    exp = m_do(1, 32'h102, 4'b0100, 32'h00AA0000);
    checks++; if (nr !== 1 || rdata !== exp) begin errors++; $display("FAIL sb_write got resp %0d rdata %h exp 1/%h", nr, rdata, exp); end
    txn3(1, 0, 32'h100, 4'h0, 32'h0, rdata, lat, nr, ne);
    exp = m_do(0, 32'h100, 4'h0, 32'h0);
    checks++; if (rdata !== exp) begin errors++; $display("FAIL sb_read got %h exp %h", rdata, exp); end
    txn3(0, 1, 32'h104, 4'b0000, 32'hFFFFFFFF, rdata, lat, nr, ne);
    void'(m_do(1, 32'h104, 4'b0000, 32'hFFFFFFFF));
    checks++; if (nr !== 1 || lat !== 3) begin errors++; $display("FAIL sb_mask0 got resp %0d lat %0d exp 1/3", nr, lat); end
  endtask

  task automatic test_alias();
    logic [31:0] rdata, exp; int lat, nr, ne;
    txn3(0, 1, 32'h0, 4'hF, 32'h0BADF00D, rdata, lat, nr, ne);
    void'(m_do(1, 32'h0, 4'hF, 32'h0BADF00D));
    txn3(0, 1, 32'h1000, 4'hF, 32'h12345678, rdata, lat, nr, ne);
    void'(m_do(1, 32'h1000, 4'hF, 32'h12345678));
    txn3(1, 0, 32'h0, 4'h0, 32'h0, rdata, lat, nr, ne);
    exp = m_do(0, 32'h0, 4'h0, 32'h0);
    checks++; if (rdata !== exp) begin errors++; $display("FAIL alias_read got %h exp %h", rdata, exp); end
    txn3(1, 0, 32'hFFFF_F003, 4'h0, 32'h0, rdata, lat, nr, ne);
    exp = m_do(0, 32'hFFFF_F003, 4'h0, 32'h0);
    checks++; if (rdata !== exp) begin errors++; $display("FAIL alias_lowbits got %h exp %h", rdata, exp); end
  endtask

  task automatic test_conflict();
    logic [31:0] rdata, exp; int lat, nr, ne;
    txn3(1, 1, 32'h8, 4'hF, 32'h55, rdata, lat, nr, ne);
    exp = m_do(1, 32'h8, 4'hF, 32'h55);
    checks++; if (ne !== 1 || nr !== 1) begin errors++; $display("FAIL conflict_pulses got err %0d resp %0d exp 1/1", ne, nr); end
    checks++; if (rdata !== exp) begin errors++; $display("FAIL conflict_rdata_hold got %h exp %h", rdata, exp); end
    checks++; if (bus3.rd_count !== exp_cnt(m_rd) || bus3.wr_count !== exp_cnt(m_wr)) begin
      errors++; $display("FAIL conflict_counts got %0d/%0d exp %0d/%0d", bus3.rd_count, bus3.wr_count, exp_cnt(m_rd), exp_cnt(m_wr)); end
    txn3(1, 0, 32'h8, 4'h0, 32'h0, rdata, lat, nr, ne);
    exp = m_do(0, 32'h8, 4'h0, 32'h0);
    checks++; if (rdata !== exp) begin errors++; $display("FAIL conflict_read got %h exp %h", rdata, exp); end
  endtask

  task automatic test_random();
    logic [31:0] rdata, exp, a, wd; logic [3:0] be; int lat, nr, ne, op; bit rd, wr;
    for (int i = 0; i < 16; i++) begin
      a = 32'h200 + 32'(4 * i);
      wd = $urandom;
      txn3(0, 1, a, 4'hF, wd, rdata, lat, nr, ne);
      void'(m_do(1, a, 4'hF, wd));
    end
    for (int n = 0; n < 80; n++) begin
      op = int'($urandom_range(0, 3));
      rd = (op != 2); wr = (op >= 2);
      a  = {$urandom_range(0, 1048575) & 32'hFFFFF, 32'h0} >> 32;
      a  = (32'($urandom) & 32'hFFFF_F000) | 32'h200 | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
      be = 4'($urandom); wd = $urandom;
      txn3(rd, wr, a, be, wd, rdata, lat, nr, ne);
      exp = m_do(wr, a, be, wd);
      checks++; if (lat !== 3 || nr !== 1 || ne !== int'(rd && wr)) begin
        errors++; $display("FAIL rnd_timing[%0d] got lat %0d resp %0d err %0d exp 3/1/%0d", n, lat, nr, ne, int'(rd && wr)); end
      checks++; if (rdata !== exp) begin errors++; $display("FAIL rnd_rdata[%0d] got %h exp %h", n, rdata, exp); end
    end
    checks++; if (bus3.rd_count !== exp_cnt(m_rd) || bus3.wr_count !== exp_cnt(m_wr)) begin
      errors++; $display("FAIL rnd_counts got %0d/%0d exp %0d/%0d", bus3.rd_count, bus3.wr_count, exp_cnt(m_rd), exp_cnt(m_wr)); end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] rdata, exp; int lat, nr, ne, seen;
    txn3(0, 1, 32'h20, 4'hF, 32'h0, rdata, lat, nr, ne);
    void'(m_do(1, 32'h20, 4'hF, 32'h0));
    @(negedge clk);
    bus3.mem_write = 1'b1; bus3.mem_address = 32'h20; bus3.mem_byte_enable = 4'hF; bus3.mem_wdata = 32'hFFFFFFFF;
    @(negedge clk);
    rst = 1'b1; bus3.mem_write = 1'b0;
    seen = 0;
    repeat (2) begin @(negedge clk); if (bus3.mem_resp) seen++; end
    checks++; if (bus3.mem_rdata !== 32'h0 || bus3.wr_count !== 16'h0) begin
      errors++; $display("FAIL mid_rst_outputs got rdata %h wrcnt %0d exp 0/0", bus3.mem_rdata, bus3.wr_count); end
    rst = 1'b0; m_rd = 0; m_wr = 0; m_last = 32'h0;
    repeat (5) begin @(negedge clk); if (bus3.mem_resp) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL mid_rst_resp got %0d pulses exp 0", seen); end
    txn3(1, 0, 32'h20, 4'h0, 32'h0, rdata, lat, nr, ne);
    exp = m_do(0, 32'h20, 4'h0, 32'h0);
    checks++; if (rdata !== exp || lat !== 3) begin errors++; $display("FAIL mid_rst_read got %h lat %0d exp %h/3", rdata, lat, exp); end
  endtask

  task automatic test_back_to_back();
    int lat; bit exp_resp;
    @(negedge clk);
    bus1.mem_write = 1'b1; bus1.mem_address = 32'h40; bus1.mem_byte_enable = 4'hF; bus1.mem_wdata = 32'hCAFEF00D;
    lat = -1;
    for (int c = 1; c <= 6 && lat < 0; c++) begin
      @(negedge clk);
      if (bus1.mem_resp) begin lat = c; bus1.mem_write = 1'b0; end
    end
    bus1.mem_write = 1'b0;
    checks++; if (lat !== 1) begin errors++; $display("FAIL b2b_write_lat got %0d exp 1", lat); end
    @(negedge clk);
    bus1.mem_read = 1'b1; bus1.mem_address = 32'h40;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      exp_resp = (c % 2) == 1;
      checks++; if (bus1.mem_resp !== exp_resp) begin errors++; $display("FAIL b2b_resp[%0d] got %b exp %b", c, bus1.mem_resp, exp_resp); end
      if (exp_resp) begin
        checks++; if (bus1.mem_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL b2b_rdata[%0d] got %h exp cafef00d", c, bus1.mem_rdata); end
      end else begin
        checks++; if (bus1.rd_count !== exp_cnt(c / 2) || bus1.wr_count !== exp_cnt(1)) begin
          errors++; $display("FAIL b2b_count[%0d] got %0d/%0d exp %0d/%0d", c, bus1.rd_count, bus1.wr_count, exp_cnt(c / 2), exp_cnt(1)); end
      end
    end
    bus1.mem_read = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_word();
    test_sub_byte();
    test_alias();
    test_conflict();
    test_random();
    test_reset_midflight();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
